// File: rtl/spi_flash_pkg.sv
// Shared opcodes, status bit positions and FSM state encoding for the SPI flash target.
package spi_flash_pkg;

  localparam logic [7:0] OP_WRITE       = 8'h02;
  localparam logic [7:0] OP_READ        = 8'h03;
  localparam logic [7:0] OP_READ_STATUS = 8'h05;
  localparam logic [7:0] OP_WREN        = 8'h06;
  localparam logic [7:0] OP_CHIP_ERASE  = 8'h60;

  localparam int STAT_WIP = 0;
  localparam int STAT_WEL = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RD_DATA,
    S_WR_DATA,
    S_STAT,
    S_IGNORE
  } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous pin, with registered rise/fall pulses
// aligned to the registered level output.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync  <= {2{RST_VAL}};
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[0], pin};
      level <= sync[1];
      rise  <= sync[1] & ~level;
      fall  <= ~sync[1] & level;
    end
  end

endmodule

// File: rtl/spi_flash_target.sv
// SPI NOR flash responder (mode 0, MSB first) backed by an on-chip byte array,
// oversampling the SPI pins from the system clock.
//
// state     | meaning
// S_IDLE    | cs high, waiting for cs fall
// S_CMD     | collecting the 8-bit opcode
// S_ADDR    | collecting the 24-bit address into ptr
// S_RD_DATA | shifting mem[ptr] out, ptr advances per byte
// S_WR_DATA | programming mem[ptr] &= byte, ptr advances per byte
// S_STAT    | shifting the status register out repeatedly
// S_IGNORE  | swallowing bits until cs rises
module spi_flash_target
  import spi_flash_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int BUSY_CYCLES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       f_sclk,
  input  logic       f_cs,
  input  logic       f_mosi,
  output logic       f_miso,
  output logic [7:0] status
);

  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .n_rst(n_rst), .pin(f_cs), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_pin_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .n_rst(n_rst), .pin(f_sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_pin_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .n_rst(n_rst), .pin(f_mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_pins;
  assign unused_pins = ^{cs_lvl, sclk_lvl, mosi_rise, mosi_fall};

  state_t                 state, state_nxt;
  logic [4:0]             bit_cnt;
  logic [6:0]             sh;
  logic [7:0]             sh_nxt;
  logic [7:0]             out_sh;
  logic                   miso_q;
  logic [7:0]             op_q;
  logic                   cmd_ok;
  logic                   wr_done;
  logic                   wip, wel;
  logic [BUSY_W-1:0]      busy_cnt;
  logic                   erasing;
  logic [ADDR_BITS:0]     erase_cnt;
  logic [ADDR_BITS-1:0]   ptr;
  logic [7:0]             mem [DEPTH];
  logic [7:0]             rd_byte;
  logic                   shifting_out;
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_wa;
  logic [7:0]             mem_wd;

  assign sh_nxt       = {sh, mosi_lvl};
  assign rd_byte      = mem[ptr];
  assign shifting_out = (state == S_RD_DATA) || (state == S_STAT);
  assign f_miso       = miso_q;

  always_comb begin
    status           = 8'h00;
    status[STAT_WIP] = wip;
    status[STAT_WEL] = wel;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (cs_fall) state_nxt = S_CMD;
        S_CMD: begin
          if (sclk_rise && bit_cnt == 5'd7) begin
            case (sh_nxt)
              OP_READ:        state_nxt = wip ? S_IGNORE : S_ADDR;
              OP_WRITE:       state_nxt = (!wip && wel) ? S_ADDR : S_IGNORE;
              OP_READ_STATUS: state_nxt = S_STAT;
              default:        state_nxt = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          if (sclk_rise && bit_cnt == 5'd23)
            state_nxt = (op_q == OP_READ) ? S_RD_DATA : S_WR_DATA;
        end
        default: ;
      endcase
    end
  end

  // Erase and program never overlap: both are only accepted while WIP is clear.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = ptr;
    mem_wd = rd_byte & sh_nxt;
    if (n_rst && erasing && !erase_cnt[ADDR_BITS]) begin
      mem_we = 1'b1;
      mem_wa = erase_cnt[ADDR_BITS-1:0];
      mem_wd = 8'hff;
    end else if (n_rst && state == S_WR_DATA && sclk_rise && !cs_rise && bit_cnt == 5'd7) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      bit_cnt   <= '0;
      sh        <= '0;
      out_sh    <= '0;
      miso_q    <= 1'b1;
      op_q      <= '0;
      cmd_ok    <= 1'b0;
      wr_done   <= 1'b0;
      wip       <= 1'b0;
      wel       <= 1'b0;
      busy_cnt  <= '0;
      erasing   <= 1'b0;
      erase_cnt <= '0;
      ptr       <= '0;
    end else begin
      if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - BUSY_W'(1);
        if (busy_cnt == BUSY_W'(1)) wip <= 1'b0;
      end
      if (erasing) begin
        if (erase_cnt[ADDR_BITS]) begin
          erasing <= 1'b0;
          wip     <= 1'b0;
        end else begin
          erase_cnt <= erase_cnt + (ADDR_BITS+1)'(1);
        end
      end
      if (!shifting_out) miso_q <= 1'b1;

      // cs rise beats a coincident sclk rise; the commit sees the prior bit count.
      if (cs_rise) begin
        miso_q <= 1'b1;
        if (op_q == OP_WREN && cmd_ok) wel <= 1'b1;
        if (op_q == OP_CHIP_ERASE && cmd_ok && wel && !wip) begin
          wip       <= 1'b1;
          wel       <= 1'b0;
          erasing   <= 1'b1;
          erase_cnt <= '0;
        end
        if (wr_done) begin
          wip      <= 1'b1;
          wel      <= 1'b0;
          busy_cnt <= BUSY_W'(BUSY_CYCLES);
        end
      end else begin
        if (cs_fall && state == S_IDLE) begin
          bit_cnt <= '0;
          op_q    <= '0;
          cmd_ok  <= 1'b0;
          wr_done <= 1'b0;
        end
        if (sclk_rise) begin
          sh      <= sh_nxt[6:0];
          bit_cnt <= bit_cnt + 5'd1;
          case (state)
            S_CMD: begin
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                op_q    <= sh_nxt;
                cmd_ok  <= 1'b1;
              end
            end
            S_ADDR: begin
              ptr <= {ptr[ADDR_BITS-2:0], mosi_lvl};
              if (bit_cnt == 5'd23) bit_cnt <= '0;
            end
            S_WR_DATA: begin
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                ptr     <= ptr + ADDR_BITS'(1);
                wr_done <= 1'b1;
              end
            end
            S_RD_DATA, S_STAT: if (bit_cnt == 5'd7) bit_cnt <= '0;
            S_IGNORE: cmd_ok <= 1'b0;
            default: ;
          endcase
        end
        // Byte load happens on the fall that ends the previous byte (or the address).
        if (sclk_fall && shifting_out) begin
          if (bit_cnt == '0) begin
            if (state == S_RD_DATA) begin
              miso_q <= rd_byte[7];
              out_sh <= {rd_byte[6:0], 1'b0};
              ptr    <= ptr + ADDR_BITS'(1);
            end else begin
              miso_q <= status[7];
              out_sh <= {status[6:0], 1'b0};
            end
          end else begin
            miso_q <= out_sh[7];
            out_sh <= {out_sh[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_target.sv
// Scoreboard bench for spi_flash_target: an SPI master drives commands, a reference
// model queues expected miso bytes, and a monitor compares captured bytes.
module tb_spi_flash_target;

  localparam int HP  = 50;
  localparam int GAP = 100;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       f_sclk = 1'b0;
  logic       f_cs = 1'b1;
  logic       f_mosi = 1'b0;
  logic       f_miso;
  logic [7:0] status;

  int total = 0;
  int bad = 0;

  logic [7:0] ref_mem [256];
  logic       ref_wel = 1'b0;
  logic       ref_busy = 1'b0;
  logic [7:0] exp_q [$];
  logic       capture = 1'b0;
  logic [7:0] wbuf [8];

  spi_flash_target #(.ADDR_BITS(8), .BUSY_CYCLES(64)) dut (
    .clk(clk), .n_rst(n_rst), .f_sclk(f_sclk), .f_cs(f_cs),
    .f_mosi(f_mosi), .f_miso(f_miso), .status(status));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    logic [7:0] rx;
    logic [7:0] e;
    int nb;
    rx = '0;
    nb = 0;
    forever begin
      @(posedge f_sclk);
      if (capture) begin
        rx = {rx[6:0], f_miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL miso_byte: got %h with nothing expected", rx);
          end else begin
            e = exp_q.pop_front();
            check("miso_byte", rx, e);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      f_mosi = b[i];
      #HP; f_sclk = 1'b1;
      #HP; f_sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    f_cs = 1'b0;
    #HP;
  endtask

  task automatic cs_end();
    #HP;
    f_cs = 1'b1;
    #GAP;
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_bits(a[23:16], 8);
    send_bits(a[15:8], 8);
    send_bits(a[7:0], 8);
  endtask

  task automatic do_wren();
    cs_begin(); send_bits(8'h06, 8); cs_end();
    ref_wel = 1'b1;
  endtask

  task automatic do_erase();
    cs_begin(); send_bits(8'h60, 8); cs_end();
    if (ref_wel && !ref_busy) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'hff;
      ref_wel  = 1'b0;
      ref_busy = 1'b1;
    end
  endtask

  task automatic do_write(input logic [23:0] a, input int n);
    cs_begin(); send_bits(8'h02, 8); send_addr(a);
    for (int i = 0; i < n; i++) send_bits(wbuf[i], 8);
    cs_end();
    if (ref_wel && !ref_busy && n > 0) begin
      for (int i = 0; i < n; i++) ref_mem[(int'(a[7:0]) + i) % 256] &= wbuf[i];
      ref_wel  = 1'b0;
      ref_busy = 1'b1;
    end
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(ref_busy ? 8'hff : ref_mem[(int'(a[7:0]) + i) % 256]);
    cs_begin(); send_bits(8'h03, 8); send_addr(a);
    capture = 1'b1;
    for (int i = 0; i < n; i++) send_bits(8'h00, 8);
    capture = 1'b0;
    cs_end();
  endtask

  task automatic do_rdsr(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({6'b0, ref_wel, ref_busy});
    cs_begin(); send_bits(8'h05, 8);
    capture = 1'b1;
    for (int i = 0; i < n; i++) send_bits(8'h00, 8);
    capture = 1'b0;
    cs_end();
  endtask

  task automatic wait_idle();
    repeat (300) @(posedge clk);
    ref_busy = 1'b0;
  endtask

  task automatic check_status(input string name);
    @(negedge clk);
    check(name, status, {6'b0, ref_wel, ref_busy});
  endtask

  initial begin
    logic [23:0] a;
    int          len;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_status", status, 8'h00);
    check("reset_miso", {7'b0, f_miso}, 8'h01);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);

    do_rdsr(3);
    check("miso_cs_high", {7'b0, f_miso}, 8'h01);

    do_wren();   check_status("wren_wel");
    do_erase();  check_status("erase_wip");
    do_rdsr(1);
    wait_idle(); check_status("erase_done");
    do_rdsr(1);
    do_read(24'h000000, 4);

    wbuf[0] = 8'h8c; wbuf[1] = 8'h25; wbuf[2] = 8'hde; wbuf[3] = 8'h89;
    do_wren(); do_write(24'h000000, 4); check_status("write_wip");
    wait_idle(); check_status("write_done_wel");
    do_read(24'h000000, 4);
    do_rdsr(1);

    wbuf[0] = 8'h00;
    do_write(24'h000010, 1); check_status("nowren_write");
    do_read(24'h000010, 1);
    do_erase(); check_status("nowren_erase");
    do_read(24'h000000, 1);

    wbuf[0] = 8'h0f; do_wren(); do_write(24'h000020, 1); wait_idle();
    wbuf[0] = 8'hf0; do_wren(); do_write(24'h000020, 1); wait_idle();
    do_read(24'h000020, 1);

    wbuf[0] = 8'h3c; wbuf[1] = 8'ha7;
    do_wren(); do_write(24'h0000ff, 2); wait_idle();
    do_read(24'h0000ff, 2);

    wbuf[0] = 8'ha5;
    do_wren(); do_write(24'h123456, 1); wait_idle();
    do_read(24'h000056, 1);

    for (int k = 0; k < 6; k++) begin
      a   = 24'($urandom);
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) wbuf[i] = 8'($urandom);
      do_wren(); do_write(a, len); check_status("rand_write_wip");
      wait_idle();
      do_read({8'($urandom), 8'($urandom), a[7:0]}, len);
    end

    cs_begin(); send_bits(8'h06, 5); cs_end();
    check_status("partial_wren");

    do_wren(); do_erase();
    do_read(24'h000000, 2);
    wait_idle(); do_rdsr(1);

    do_wren(); do_erase();
    repeat (50) @(posedge clk);
    @(negedge clk); n_rst = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    ref_wel  = 1'b0;
    ref_busy = 1'b0;
    repeat (4) @(negedge clk);
    check_status("reset_mid_erase");
    do_rdsr(1);
    repeat (300) @(posedge clk);
    check_status("reset_erase_abandoned");

    repeat (20) @(posedge clk);
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
